ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver; successor to the single-byte ASCII receiver.
//  Receives PS/2 device-to-host frames and checks start, odd parity and stop bits, with a
//  frame timeout. Folds E0/F0 prefixes into one make/break event per key and buffers events
//  in a FIFO with a valid/ready interface. Sits between the PS/2 pins and the
//  scancode decoder / CPU I/O port.
// PARAMETERS
//  SYNC_STAGES     2      synchroniser flops on ps2_clk and ps2_dat (>=2)
//  FILTER_LEN      4      consecutive equal samples before a filtered ps2_clk level change (>=1)
//  TIMEOUT_CYCLES  50000  clk cycles with no PS/2 falling edge before an active frame aborts
//  FIFO_DEPTH      8      event FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  rst_n       in   1   asynchronous active-low reset
//  ps2_clk     in   1   raw PS/2 clock pin (asynchronous)
//  ps2_dat     in   1   raw PS/2 data pin (asynchronous)
//  ev_data     out  10  head event {brk, ext, code[7:0]}
//  ev_valid    out  1   FIFO not empty
//  ev_ready    in   1   consumer accepts head; pop when ev_valid && ev_ready
//  fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held
//  overflow    out  1   sticky: an event was dropped because the FIFO was full
//  ovf_clr     in   1   clears overflow (push-drop in the same cycle wins, overflow stays 1)
//  frame_err   out  1   1-cycle pulse: parity, stop or timeout error
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM IDLE, prefixes cleared, FIFO empty, all outputs 0;
//    synchroniser and filter registers reset to 1 (bus idle high).
//  - Filter: filtered ps2_clk changes only after FILTER_LEN equal synchronised samples.
//    Falling edge = filtered 1->0; ps2_dat is sampled (synchronised) in that cycle.
//  - Frame FSM (advances only on a falling edge):
//    IDLE   dat=0 -> DATA, bit_cnt=0; dat=1 -> stay (no error).
//    DATA   shift 8 bits LSB first; after bit 7 -> PARITY.
//    PARITY capture p -> STOP.
//    STOP   if dat=1 and ^{byte,p}==1 -> byte_ok; else frame_err; always -> IDLE.
//  - Timeout: counter clears on every falling edge and in IDLE. Outside IDLE, count reaching
//    TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, partial byte discarded.
//  - Any frame_err also clears the ext/brk prefix flags.
//  - Decode on byte_ok: 0xE0 sets ext; 0xF0 sets brk; 0x00/0xFF are discarded, no event,
//    no error. Any other byte emits {brk,ext,byte} and clears ext and brk.
//  - Latency: stop bit sampled in cycle T -> event registered T+1 -> written T+2.
//    ev_valid is high from T+2 when the FIFO was empty.
//  - FIFO is first-word-fall-through; ev_data holds the head, and holds 0 when empty.
//  - Full with no pop: the event is dropped and overflow is set.
//  - Full with a pop in the same cycle: both happen, level unchanged.
//  - Empty: ev_ready is ignored. Pointers wrap modulo FIFO_DEPTH.
//  - Reset mid-frame: the frame is lost. The FSM resynchronises on the next start bit after
//    idle; a mid-frame edge with dat=1 is ignored, and one with dat=0 is caught by parity,
//    stop or timeout.
// CONFIGURATION
//  PS2_REPEAT_FILTER_EN defined: a tracker holds the last make {ext,code}.
//    - A make equal to the tracker is dropped (typematic repeat).
//    - A break equal to the tracker clears it; both makes and breaks are still pushed.
//    - Reset and frame_err clear the tracker.
//  Not defined: every make and break event is pushed; no tracker logic.
// TESTING
//  1 frame 0x1C, parity 0, stop 1 -> ev_data=10'h01C, ev_valid at T+2, level=1; frame_err never pulses.
//  2 frames E0,F0,75 -> exactly one event, ev_data=10'h375; ext/brk cleared afterwards.
//  3 frame 0x1C with parity 1 -> frame_err 1 cycle, no event; next good 0x1C -> 10'h01C.
//  4 start+4 bits then ps2_clk held high TIMEOUT_CYCLES -> frame_err, FSM IDLE; next frame 0x29 -> 10'h029.
//  5 ev_ready=0, FIFO_DEPTH+1 codes 0x15.. -> level=FIFO_DEPTH, overflow=1, first DEPTH codes drain in order; ovf_clr -> 0.
//  6 1C,1C,1C,F0,1C -> with macro: 10'h01C then 10'h21C; without macro: 3x 10'h01C then 10'h21C.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host receiver folding E0/F0 prefixes into make/break events in a FIFO.
// Optional typematic-repeat suppression is enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_dat,
    output logic [9:0]                        ev_data,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    input  logic                              ovf_clr,
    output logic                              frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_filt;
    logic [FCW-1:0]         r_filt_cnt;
    logic                   w_clk_s, w_dat_s, w_fall;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic [TCW-1:0] r_to_cnt;
    logic       w_byte_ok, w_err, w_timeout;

    logic       r_ext, r_brk;
    logic       r_ev_push;
    logic [9:0] r_ev_data;
    logic       r_frame_err;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          w_full, w_empty, w_push, w_pop;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_clk_filt <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // The fall is recognised in the same cycle the filtered level flips to 0.
    assign w_fall = r_clk_filt && !w_clk_s && (r_filt_cnt == FCW'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat_s) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    if (w_dat_s && (^{r_shift, r_par})) w_byte_ok = 1'b1;
                    else                               w_err     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 1'b1;
            if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_par <= w_dat_s;
                    default:  ;
                endcase
            end
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       r_trk_vld;
    logic [8:0] r_trk;
    logic       w_trk_match;
    assign w_trk_match = r_trk_vld && (r_trk == {r_ext, r_shift});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_ev_push   <= 1'b0;
            r_ev_data   <= '0;
            r_frame_err <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            r_trk_vld   <= 1'b0;
            r_trk       <= '0;
`endif
        end else begin
            r_ev_push   <= 1'b0;
            r_frame_err <= w_err;
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                r_trk_vld <= 1'b0;
`endif
            end else if (w_byte_ok) begin
                case (r_shift)
                    8'hE0:        r_ext <= 1'b1;
                    8'hF0:        r_brk <= 1'b1;
                    8'h00, 8'hFF: ;
                    default: begin
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                        r_ev_data <= {r_brk, r_ext, r_shift};
`ifdef PS2_REPEAT_FILTER_EN
                        if (r_brk) begin
                            r_ev_push <= 1'b1;
                            if (w_trk_match) r_trk_vld <= 1'b0;
                        end else if (!w_trk_match) begin
                            r_ev_push <= 1'b1;
                            r_trk     <= {r_ext, r_shift};
                            r_trk_vld <= 1'b1;
                        end
`else
                        r_ev_push <= 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && ev_ready;
    assign w_push  = r_ev_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_ev_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
            if (r_ev_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (ovf_clr)                  r_overflow <= 1'b0;
        end
    end

    assign ev_valid   = !w_empty;
    assign ev_data    = w_empty ? 10'd0 : r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed table-driven bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;

    localparam int TO    = 300;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       frame_err;

    ps2_scancode_rx #(
        .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        int         exp_ev;
        logic [9:0] exp_data;
        int         exp_err;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] got[$];
    int         err_cnt = 0;
    int         err_long = 0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ev_valid && ev_ready) got.push_back(ev_data);
            if (frame_err && !prev_err) err_cnt++;
            if (frame_err && prev_err)  err_long++;
            prev_err = frame_err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(5);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
    endtask

    vec_t vecs[15];

    initial begin
        int nb, eb;
        logic [9:0] exp_q[$];

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 10'h01C, 0};
        vecs[1]  = '{8'h1C, 1'b1, 1'b0, 0, 10'h000, 1};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 10'h01C, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b0, 1, 10'h375, 0};
        vecs[6]  = '{8'h29, 1'b0, 1'b0, 1, 10'h029, 0};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[8]  = '{8'hFF, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[10] = '{8'h1F, 1'b0, 1'b1, 0, 10'h000, 1};
        vecs[11] = '{8'h4A, 1'b0, 1'b0, 1, 10'h04A, 0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 0, 10'h000, 0};
        vecs[13] = '{8'h1C, 1'b0, 1'b0, 1, 10'h21C, 0};
        vecs[14] = '{8'h5A, 1'b0, 1'b0, 1, 10'h05A, 0};

        wait_cyc(5);
        check("reset ev_valid", 32'(ev_valid), 32'd0);
        check("reset ev_data", 32'(ev_data), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        for (int v = 0; v < 15; v++) begin
            nb = got.size();
            eb = err_cnt;
            send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop);
            wait_cyc(20);
            check($sformatf("vec%0d event count", v), 32'(got.size() - nb), 32'(vecs[v].exp_ev));
            if (vecs[v].exp_ev == 1 && got.size() > nb)
                check($sformatf("vec%0d ev_data", v), 32'(got[nb]), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d frame_err pulses", v), 32'(err_cnt - eb), 32'(vecs[v].exp_err));
        end

        // Partial frame followed by a stalled clock must time out.
        nb = got.size();
        eb = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        wait_cyc(TO + 20);
        check("timeout frame_err", 32'(err_cnt - eb), 32'd1);
        check("timeout no event", 32'(got.size() - nb), 32'd0);
        send_frame(8'h29, 1'b0, 1'b0);
        wait_cyc(20);
        check("post-timeout event count", 32'(got.size() - nb), 32'd1);
        if (got.size() > nb) check("post-timeout ev_data", 32'(got[nb]), 32'h029);

        // Fill past depth with the consumer stalled.
        ev_ready = 1'b0;
        nb = got.size();
        send_frame(8'h15, 1'b0, 1'b0);
        wait_cyc(20);
        check("single fifo_level", 32'(fifo_level), 32'd1);
        check("single ev_valid", 32'(ev_valid), 32'd1);
        check("single ev_data", 32'(ev_data), 32'h015);
        for (int k = 1; k <= DEPTH; k++) send_frame(8'h15 + 8'(k), 1'b0, 1'b0);
        wait_cyc(20);
        check("full fifo_level", 32'(fifo_level), 32'(DEPTH));
        check("full overflow", 32'(overflow), 32'd1);
        check("full head", 32'(ev_data), 32'h015);
        ev_ready = 1'b1;
        wait_cyc(20);
        check("drain count", 32'(got.size() - nb), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++)
            if (got.size() > nb + k)
                check($sformatf("drain %0d", k), 32'(got[nb + k]), 32'h015 + 32'(k));
        check("drained level", 32'(fifo_level), 32'd0);
        check("drained ev_valid", 32'(ev_valid), 32'd0);
        check("drained ev_data", 32'(ev_data), 32'd0);
        check("overflow sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        check("overflow cleared", 32'(overflow), 32'd0);

        // Typematic repeat sequence.
        nb = got.size();
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_cyc(20);
`ifdef PS2_REPEAT_FILTER_EN
        exp_q = '{10'h01C, 10'h21C};
`else
        exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h21C};
`endif
        check("repeat event count", 32'(got.size() - nb), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (got.size() > nb + k)
                check($sformatf("repeat %0d", k), 32'(got[nb + k]), 32'(exp_q[k]));

        check("frame_err single-cycle", 32'(err_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
